instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of instruction_decode. Holds the PC and issues word

---
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem request/response, prefetch FIFO toward decode, redirect flush.
// Optional IF_PERF_COUNTERS_EN adds perf_fetched / perf_dropped counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);

  typedef enum logic {BOOT, RUN} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic          run;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  entry_t        fifo_q [FIFO_DEPTH];
  logic [CW:0]   credit_used;
  logic          req_fire, push, pop, resp_drop;
  logic          unused_redir_lsbs;

  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb run = (state_q == RUN);

  // Outstanding includes responses already marked for drop, so in-flight never exceeds FIFO_DEPTH.
  always_comb begin
    credit_used    = {1'b0, outst_q} + {1'b0, cnt_q};
    imem_req_valid = run && !redirect_valid && (credit_used < DEPTH_W);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = (cnt_q != '0);
    out_instr      = fifo_q[rd_q].instr;
    out_pc         = fifo_q[rd_q].pc;
    pop            = out_valid && out_ready;
    resp_drop      = imem_resp_valid && (redirect_valid || drop_q != '0);
    push           = imem_resp_valid && !resp_drop;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      drop_d     = outst_q - CW'(imem_resp_valid);
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
    end else begin
      if (imem_resp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_d      = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= '{pc: resp_pc_q, instr: imem_resp_data};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && cnt_q == DEPTH_CW));
  end
`endif

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0]   perf_fetched_q, perf_dropped_q;
  logic [CW-1:0] flushed;

  // The head popped in a redirect cycle was consumed, not flushed.
  assign flushed = redirect_valid ? (cnt_q - CW'(pop)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(pop);
      perf_dropped_q <= perf_dropped_q + 32'(flushed) + 32'(resp_drop);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: in-order memory model plus a PC-stream scoreboard.
module tb_instruction_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] SALT  = 32'hC001_D00D;

  logic        clk = 1'b0, rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef IF_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  // Environment and reference state
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          cyc, last_due, n_issued, n_pop;
  logic [31:0] exp_req, exp_pc;
  int          p_rdy, p_ordy, p_redir, lat_lo, lat_hi;
  logic        do_redir;
  logic [31:0] redir_tgt;
  logic        s_reqv, s_outv, s_resp;
  logic [31:0] s_addr, s_opc;

  task automatic do_reset();
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqv", imem_req_valid, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_addr", imem_req_addr, RPC);
`ifdef IF_PERF_COUNTERS_EN
    chk("rst_pf", perf_fetched, 0);
    chk("rst_pd", perf_dropped, 0);
`endif
    rst = 1'b0;
    mem_addr.delete(); mem_due.delete();
    cyc = 0; last_due = 0; n_issued = 0; n_pop = 0;
    exp_req = RPC; exp_pc = RPC; do_redir = 1'b0;
    #1;
    chk("boot_reqv", imem_req_valid, 0);
  endtask

  task automatic step();
    int lat, due;
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(mem_addr[0]);
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_ordy);
    redirect_valid = do_redir || ($urandom_range(999) < p_redir);
    redirect_pc    = do_redir ? redir_tgt : $urandom;
    do_redir       = 1'b0;
    #1;
    s_reqv = imem_req_valid; s_addr = imem_req_addr;
    s_outv = out_valid;      s_opc  = out_pc;
    s_resp = imem_resp_valid;
`ifdef IF_PERF_COUNTERS_EN
    chk("perf_fetched", perf_fetched, n_pop);
    // With the FIFO empty, every issued request is popped, dropped or still in flight.
    if (!s_outv)
      chk("perf_dropped", perf_dropped, n_issued - n_pop - (mem_addr.size() + int'(s_resp)));
`endif
    if (s_reqv && imem_req_ready) begin
      chk("req_addr", s_addr, exp_req);
      exp_req += 32'd4;
      lat = $urandom_range(lat_hi, lat_lo);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_addr.push_back(s_addr);
      mem_due.push_back(due);
      n_issued++;
      chk("inflight", (mem_addr.size() + int'(s_resp)) <= DEPTH, 1);
    end
    if (s_outv && out_ready) begin
      chk("out_pc", s_opc, exp_pc);
      chk("out_instr", out_instr, memf(exp_pc));
      exp_pc += 32'd4;
      n_pop++;
    end
    if (redirect_valid) begin
      chk("req_in_redir", s_reqv, 0);
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_pc  = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic step_until_pop(input string tag, output logic [31:0] pc);
    logic found = 1'b0;
    pc = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (s_outv && out_ready) begin
        found = 1'b1;
        pc = s_opc;
      end
    end
    chk({tag, "_timeout"}, found, 1);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    do_redir = 1'b1;
    redir_tgt = tgt;
    step();
  endtask

  initial begin
    logic [31:0] pc;
    p_rdy = 100; p_ordy = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;

    // Streaming with single-cycle memory
    do_reset();
    step(); chk("t1_first_reqv", s_reqv, 1); chk("t1_first_addr", s_addr, 32'h0);
    step();
    step(); chk("t1_first_outv", s_outv, 1); chk("t1_first_pc", s_opc, 32'h0);
    repeat (20) step();
    chk("t1_rate", n_pop, 21);

    // Decode stall: credit stops fetch at FIFO_DEPTH
    do_reset();
    p_ordy = 0;
    repeat (20) step();
    chk("t2_reqv_off", s_reqv, 0);
    chk("t2_issued", exp_req, 32'h10);
    p_ordy = 100;
    for (int i = 0; i < 4; i++) begin
      step_until_pop("t2_pop", pc);
      chk("t2_pc", pc, 32'(i * 4));
    end
    step_until_pop("t2_resume", pc);
    chk("t2_resume_pc", pc, 32'h10);

    // Redirect with responses in flight from slow memory
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && mem_addr.size() < 2; i++) step();
    chk("t3_inflight", mem_addr.size() >= 2, 1);
    redirect_to(32'h100);
    step_until_pop("t3_pop", pc);
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", out_instr, memf(32'h100));

    // Redirect coinciding with a response and an output handshake
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    redirect_to(32'h200);
    chk("t4_setup", s_resp && s_outv && out_ready, 1);
    step_until_pop("t4_pop", pc);
    chk("t4_pc", pc, 32'h200);

    // Unaligned target near the top of the address space wraps
    redirect_to(32'hFFFF_FFFF);
    step_until_pop("t5_pop0", pc);
    chk("t5_pc0", pc, 32'hFFFF_FFFC);
    step_until_pop("t5_pop1", pc);
    chk("t5_pc1", pc, 32'h0000_0000);

    // Random traffic: stalls on both sides, variable latency, frequent redirects
    p_rdy = 70; p_ordy = 70; p_redir = 30; lat_lo = 1; lat_hi = 4;
    repeat (3000) step();
    chk("live", n_pop > 200, 1);

    // Reset mid-stream, then clean traffic again
    do_reset();
    p_redir = 10;
    repeat (1000) step();
    chk("live2", n_pop > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
